// File: rtl/enc_pkg.sv
// Shared types and default sizing for the encoder step controller.
package enc_pkg;

    typedef enum logic {ST_IDLE, ST_CHECK} enc_state_t;

    localparam int unsigned ENC_STABLE_CYC_DFLT = 256;
    localparam int unsigned ENC_CNT_W_DFLT      = 8;
    localparam int unsigned ENC_GLITCH_W        = 8;

endpackage

// File: rtl/enc_step_ctrl_if.sv
// Encoder controller signal bundle; glitch_cnt is present only with ENC_GLITCH_CNT_EN.
interface enc_step_ctrl_if
    import enc_pkg::*;
#(
    parameter int unsigned CNT_W = ENC_CNT_W_DFLT
);
    logic             enc;
    logic             clr;
    logic             enc_db;
    logic             rise_p;
    logic             fall_p;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;
`ifdef ENC_GLITCH_CNT_EN
    logic [ENC_GLITCH_W-1:0] glitch_cnt;

    modport master (
        output enc, clr,
        input  enc_db, rise_p, fall_p, step_cnt, busy, glitch_cnt
    );
    modport slave (
        input  enc, clr,
        output enc_db, rise_p, fall_p, step_cnt, busy, glitch_cnt
    );
`else
    modport master (
        output enc, clr,
        input  enc_db, rise_p, fall_p, step_cnt, busy
    );
    modport slave (
        input  enc, clr,
        output enc_db, rise_p, fall_p, step_cnt, busy
    );
`endif
endinterface

// File: rtl/enc_sync.sv
// SYNC_STG-deep flop chain bringing the raw encoder line into the clk domain.
module enc_sync #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STG-1:0] stg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= {stg_q[SYNC_STG-2:0], d};
        end
    end

    assign q = stg_q[SYNC_STG-1];
endmodule

// File: rtl/enc_step_ctrl.sv
// Debounces one encoder line, emits edge pulses and counts accepted rises.
// Optional ENC_GLITCH_CNT_EN adds a saturating count of rejected glitches.
module enc_step_ctrl
    import enc_pkg::*;
#(
    parameter int unsigned STABLE_CYC = ENC_STABLE_CYC_DFLT,
    parameter int unsigned CNT_W      = ENC_CNT_W_DFLT,
    parameter int unsigned SYNC_STG   = 2
) (
    input logic            clk,
    input logic            rst,
    enc_step_ctrl_if.slave bus
);
    localparam int unsigned     CW       = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYC - 1);

    enc_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             enc_s;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] step_q, step_d;

    enc_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.enc),
        .q   (enc_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_s != db_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = CW'(1);
                end
            end
            ST_CHECK: begin
                if (enc_s == db_q) begin
                    // Any return to the settled level discards all progress.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    db_d    = enc_s;
                    rise_d  = enc_s;
                    fall_d  = ~enc_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // clr takes priority over a coincident rise.
    always_comb begin
        step_d = step_q;
        if (bus.clr) begin
            step_d = '0;
        end else if (rise_q) begin
            step_d = step_q + CNT_W'(1);
        end
    end

`ifdef ENC_GLITCH_CNT_EN
    logic [ENC_GLITCH_W-1:0] glitch_q;
    logic                    reject;

    assign reject = (state_q == ST_CHECK) && (enc_s == db_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_q <= '0;
        end else if (bus.clr) begin
            glitch_q <= '0;
        end else if (reject && (glitch_q != '1)) begin
            glitch_q <= glitch_q + ENC_GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif

    assign bus.enc_db   = db_q;
    assign bus.rise_p   = rise_q;
    assign bus.fall_p   = fall_q;
    assign bus.step_cnt = step_q;
    assign bus.busy     = (state_q == ST_CHECK);
endmodule

// File: tb/tb_enc_step_ctrl.sv
// Directed bench: default-size controller with a pulse scoreboard, plus a small
// instance (STABLE_CYC=4, CNT_W=2) for counter wrap and clr priority.
module tb_enc_step_ctrl;
    import enc_pkg::*;

    typedef struct {
        bit          rise;
        int unsigned cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    ev_t         sbq[$];
    logic        busy_seen;

    enc_step_ctrl_if #(.CNT_W(8)) b1 ();
    enc_step_ctrl_if #(.CNT_W(2)) b2 ();

    enc_step_ctrl #(
        .STABLE_CYC (256),
        .CNT_W      (8),
        .SYNC_STG   (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    enc_step_ctrl #(
        .STABLE_CYC (4),
        .CNT_W      (2),
        .SYNC_STG   (2)
    ) u_dut_small (
        .clk (clk),
        .rst (rst2),
        .bus (b2)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (b1.rise_p === 1'b1 || b1.fall_p === 1'b1) begin
            total++;
            assert (sbq.size() != 0)
            else begin
                bad++;
                $error("FAIL pulse_unexpected observed rise=%0b fall=%0b at cyc=%0d expected none",
                       b1.rise_p, b1.fall_p, cyc);
            end
            if (sbq.size() != 0) begin
                ev_t e;
                e = sbq.pop_front();
                chk("pulse_kind", {30'd0, b1.rise_p, b1.fall_p}, {30'd0, e.rise, ~e.rise});
                chk("pulse_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        // Reset hold with enc toggling
        rst      = 1'b0;
        rst2     = 1'b0;
        b1.enc   = 1'b1;
        b1.clr   = 1'b0;
        b2.enc   = 1'b1;
        b2.clr   = 1'b0;
        #3 b1.enc = 1'b0;
        #2;
        chk("rst_outs_a", {b1.enc_db, b1.rise_p, b1.fall_p, b1.busy, b1.step_cnt}, 32'd0);
        #1 b1.enc = 1'b1;
        #5 chk("rst_outs_b", {b1.enc_db, b1.rise_p, b1.fall_p, b1.busy, b1.step_cnt}, 32'd0);
        #1 b1.enc = 1'b0;
        b2.enc = 1'b0;
        #3 rst = 1'b1;
        rst2 = 1'b1;
        #1 chk("rel_db_busy", {b1.enc_db, b1.busy}, 32'd0);
        wait_cyc(1);

        // Noise burst: 0,1,0,1,0,1,0 at 5 cycles each
        for (int k = 0; k < 7; k++) begin
            b1.enc    = k[0];
            busy_seen = 1'b0;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                busy_seen = busy_seen | b1.busy;
            end
            @(posedge clk);
            #1;
            if (k[0]) chk("noise_busy", {31'd0, busy_seen}, 32'd1);
        end
        wait_cyc(20);
        chk("noise_db", {31'd0, b1.enc_db}, 32'd0);
        chk("noise_idle", {31'd0, b1.busy}, 32'd0);
        chk("noise_step", {24'd0, b1.step_cnt}, 32'd0);
`ifdef ENC_GLITCH_CNT_EN
        chk("noise_glitch", {24'd0, b1.glitch_cnt}, 32'd3);
`endif

        // Accepted rise
        sbq.push_back('{rise: 1'b1, cyc: cyc + 258});
        b1.enc = 1'b1;
        wait_cyc(500);
        chk("rise_db", {31'd0, b1.enc_db}, 32'd1);
        chk("rise_step", {24'd0, b1.step_cnt}, 32'd1);
        chk("rise_sb_empty", sbq.size(), 32'd0);

        // Accepted fall, then a second rise
        sbq.push_back('{rise: 1'b0, cyc: cyc + 258});
        b1.enc = 1'b0;
        wait_cyc(500);
        chk("fall_db", {31'd0, b1.enc_db}, 32'd0);
        chk("fall_step", {24'd0, b1.step_cnt}, 32'd1);
        sbq.push_back('{rise: 1'b1, cyc: cyc + 258});
        b1.enc = 1'b1;
        wait_cyc(500);
        chk("rise2_db", {31'd0, b1.enc_db}, 32'd1);
        chk("rise2_step", {24'd0, b1.step_cnt}, 32'd2);
        chk("rise2_sb_empty", sbq.size(), 32'd0);

        // Wrap on the small instance: 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            b2.enc = 1'b1;
            wait_cyc(20);
            chk("wrap_step", {30'd0, b2.step_cnt}, (i + 1) % 4);
            b2.enc = 1'b0;
            wait_cyc(20);
        end

        // clr coinciding with rise_p wins
        b2.enc = 1'b1;
        wait_cyc(6);
        chk("clr_rise_cycle", {31'd0, b2.rise_p}, 32'd1);
        b2.clr = 1'b1;
        wait_cyc(1);
        b2.clr = 1'b0;
        chk("clr_priority", {30'd0, b2.step_cnt}, 32'd0);
        chk("clr_db_kept", {31'd0, b2.enc_db}, 32'd1);

        // Reset mid-qualification
        sbq.push_back('{rise: 1'b0, cyc: cyc + 258});
        b1.enc = 1'b0;
        wait_cyc(300);
        chk("pre_rst_db", {31'd0, b1.enc_db}, 32'd0);
        b1.enc = 1'b1;
        wait_cyc(100);
        chk("midq_busy", {31'd0, b1.busy}, 32'd1);
        rst = 1'b0;
        #1 chk("midq_rst_outs", {b1.enc_db, b1.rise_p, b1.fall_p, b1.busy, b1.step_cnt}, 32'd0);
        wait_cyc(5);
        rst = 1'b1;
        sbq.push_back('{rise: 1'b1, cyc: cyc + 258});
        wait_cyc(300);
        chk("midq_db", {31'd0, b1.enc_db}, 32'd1);
        chk("midq_step", {24'd0, b1.step_cnt}, 32'd1);
        chk("final_sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enc_step_ctrl.md
Name: enc_step_ctrl

Overview:
- Controller that conditions a single noisy encoder line.
- Synchronises the raw `enc` input, rejects glitches shorter than a programmable stability window, and produces a debounced level plus one-cycle edge pulses.
- Keeps a wrapping step counter of accepted rising edges.
- Sits between the raw encoder pin and the encoder/position logic; it is the block that decides when an encoder transition is real.

Parameters:
- STABLE_CYC, 256, consecutive synchronised cycles the input must differ from `enc_db` before the change is accepted; legal range 2..65535.
- CNT_W, 8, width of `step_cnt`.
- SYNC_STG, 2, synchroniser depth in flops; legal range 2..3.

Ports:
- clk  input  1  system clock (50 MHz nominal, 20 ns period).
- rst  input  1  asynchronous, active-low reset.
- enc  input  1  raw, asynchronous encoder line.
- clr  input  1  synchronous clear of `step_cnt`.
- enc_db  output  1  debounced encoder level.
- rise_p  output  1  one-cycle pulse on an accepted 0->1 transition.
- fall_p  output  1  one-cycle pulse on an accepted 1->0 transition.
- step_cnt  output  CNT_W  count of accepted rising edges; wraps.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset is asynchronous on `rst`==0 and released synchronously. All flops reset to these values:
  - synchroniser flops 0, `enc_db` 0, `rise_p`/`fall_p` 0, `step_cnt` 0, `busy` 0;
  - state ST_IDLE, stability counter 0.
- `enc_s` is `enc` after SYNC_STG flops. The FSM uses only `enc_s`.
- Stability counter width is clog2(STABLE_CYC+1).
- ST_IDLE:
  - Entered with the counter at 0.
  - If `enc_s` != `enc_db`, go to ST_CHECK with counter=1.
  - Otherwise stay.
- ST_CHECK (`busy`=1):
  - If `enc_s` == `enc_db`: glitch rejected; counter=0; go to ST_IDLE; no pulse.
  - Else if counter == STABLE_CYC-1: in the same cycle, `enc_db` <= `enc_s`; drive `rise_p` or `fall_p` for exactly one cycle (registered, aligned with the `enc_db` update); counter=0; go to ST_IDLE.
  - Else counter++.
- Latency from an `enc` edge to the `enc_db` change is SYNC_STG + STABLE_CYC cycles. With defaults that is 258 cycles (5160 ns).
- Any return of `enc_s` to the `enc_db` level during qualification restarts qualification from zero. There is no partial credit.
- `rise_p` and `fall_p` are never high simultaneously and never high on consecutive cycles.
- `step_cnt`:
  - Increments by 1 on each `rise_p`.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - `clr`=1 sets it to 0 on the next edge.
  - `clr` and `rise_p` in the same cycle: `clr` wins and the result is 0.
- `clr` does not affect the FSM, `enc_db`, or the pulses.
- `rst` asserted mid-qualification: immediate return to reset values. No pulse is emitted and the partial count is discarded.
- `enc` X/Z is not supported; the bench must drive a defined level before releasing `rst`.

Optional Feature:
- Macro ENC_GLITCH_CNT_EN.
- Defined:
  - Adds output `glitch_cnt` (8-bit) that increments on every ST_CHECK->ST_IDLE rejection.
  - Saturates at 255.
  - Cleared by `rst` and by `clr`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package `enc_pkg` holds:
  - typedef enum logic {ST_IDLE, ST_CHECK} enc_state_t;
  - constants ENC_STABLE_CYC_DFLT=256, ENC_CNT_W_DFLT=8, ENC_GLITCH_W=8.
- Sub-module `enc_sync` is the parameterised SYNC_STG-deep flop chain with async active-low reset. It is instantiated once in `enc_step_ctrl`.
- FSM, stability counter, and step counter live in the top module.

Test Plan (20 ns clock, default parameters unless noted):
- Reset hold: `rst`=0 for 15 ns with `enc` toggling → all outputs 0 throughout; release at 15 ns → `enc_db`=0, `busy`=0.
- Noise burst: seven alternating 100 ns `enc` levels (5 cycles each), then hold at 0 → `busy` pulses, `enc_db` stays 0, no `rise_p`; with ENC_GLITCH_CNT_EN, `glitch_cnt`=3.
- Accepted rise: `enc` 0→1, held 10 µs → `rise_p` exactly one cycle, 258 cycles after the edge; `enc_db`=1; `step_cnt`=1.
- Accepted fall, then a second rise: `enc` 1→0 held 10 µs, then 0→1 held 10 µs → one `fall_p`, then one `rise_p`; `step_cnt`=2.
- Wrap and clr priority: CNT_W=2, STABLE_CYC=4, five accepted rises → `step_cnt` sequence 1,2,3,0,1. Then assert `clr` in the `rise_p` cycle → `step_cnt`=0.
- Reset mid-qualification: `enc` 0→1, assert `rst` after 100 cycles, release, keep `enc`=1 → no pulse before reset. Qualification restarts, and `rise_p` occurs 258 cycles after `rst` release.
